// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types, level helper and parameter range limits for the sync FIFO
package fifo_pkg;

    typedef enum logic {
        FIFO_REG  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int AF_THRESH_MIN = 1;
    localparam int AE_THRESH_MIN = 0;

    function automatic bit fifo_af_ok(input int af_thresh, input int asize);
        return (af_thresh >= AF_THRESH_MIN) && (af_thresh <= (1 << asize));
    endfunction

    function automatic bit fifo_ae_ok(input int ae_thresh, input int asize);
        return (ae_thresh >= AE_THRESH_MIN) && (ae_thresh <= (1 << asize) - 1);
    endfunction

    // Pointers carry one extra wrap bit, so the difference modulo 2^(asize+1) is the fill level.
    function automatic logic [31:0] fifo_level(input logic [31:0] wptr,
                                               input logic [31:0] rptr,
                                               input int          asize);
        logic [31:0] mask;
        mask = (32'd1 << (asize + 1)) - 32'd1;
        return (wptr - rptr) & mask;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - FIFO storage array, synchronous write and asynchronous read
module fifo_mem #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             i_wen,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    localparam int MEMDEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] r_mem [MEMDEPTH];

    always_ff @(posedge clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/beh_sync_fifo.sv
// rtl/beh_sync_fifo.sv - single-clock FIFO with level, almost flags, sticky errors, REG/FWFT read
module beh_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = (1 << ASIZE) - 2,
    parameter int AE_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   level,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam int          MEMDEPTH = 1 << ASIZE;
    localparam fifo_mode_e  MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;
    localparam logic [ASIZE:0] FULL_L = (ASIZE + 1)'(MEMDEPTH);
    localparam logic [ASIZE:0] AF_L   = (ASIZE + 1)'(AF_THRESH);
    localparam logic [ASIZE:0] AE_L   = (ASIZE + 1)'(AE_THRESH);

    if (!fifo_af_ok(AF_THRESH, ASIZE)) begin : g_bad_af
        $error("AF_THRESH out of range 1..MEMDEPTH");
    end
    if (!fifo_ae_ok(AE_THRESH, ASIZE)) begin : g_bad_ae
        $error("AE_THRESH out of range 0..MEMDEPTH-1");
    end

    logic [ASIZE:0]   r_wptr;
    logic [ASIZE:0]   r_rptr;
    logic [DSIZE-1:0] r_rdata;
    logic             r_overflow;
    logic             r_underflow;
    logic [ASIZE:0]   w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_en;
    logic             w_rd_en;
    logic [DSIZE-1:0] w_mem_rdata;

    assign w_level = (ASIZE + 1)'(fifo_level(32'(r_wptr), 32'(r_rptr), ASIZE));
    assign w_full  = (w_level == FULL_L);
    assign w_empty = (w_level == '0);
    assign w_wr_en = winc && !w_full;
    assign w_rd_en = rinc && !w_empty;

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk     (clk),
        .i_wen   (w_wr_en),
        .i_waddr (r_wptr[ASIZE-1:0]),
        .i_wdata (wdata),
        .i_raddr (r_rptr[ASIZE-1:0]),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Registered mode captures the head word on the pop edge; unused in FWFT mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_rd_en) begin
            r_rdata <= w_mem_rdata;
        end
    end

    // A set event beats err_clr in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc && w_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rinc && w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign rdata         = (MODE == FIFO_FWFT) ? w_mem_rdata : r_rdata;
    assign level         = w_level;
    assign wfull         = w_full;
    assign rempty        = w_empty;
    assign walmost_full  = (w_level >= AF_L);
    assign ralmost_empty = (w_level <= AE_L);
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule

// File: tb/tb_beh_sync_fifo.sv
// tb/tb_beh_sync_fifo.sv - directed self-checking bench for beh_sync_fifo in REG and FWFT modes
module tb_beh_sync_fifo;

    localparam int DSIZE = 8;
    localparam int ASIZE = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             rinc;
    logic             err_clr;

    logic             r0_wfull, r0_waf, r0_rempty, r0_rae, r0_ovf, r0_unf;
    logic [DSIZE-1:0] r0_rdata;
    logic [ASIZE:0]   r0_level;
    logic             f1_wfull, f1_waf, f1_rempty, f1_rae, f1_ovf, f1_unf;
    logic [DSIZE-1:0] f1_rdata;
    logic [ASIZE:0]   f1_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    beh_sync_fifo #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)
    ) u_reg (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc),
        .wfull(r0_wfull), .walmost_full(r0_waf), .rinc(rinc), .rdata(r0_rdata),
        .rempty(r0_rempty), .ralmost_empty(r0_rae), .level(r0_level),
        .overflow(r0_ovf), .underflow(r0_unf), .err_clr(err_clr)
    );

    beh_sync_fifo #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc),
        .wfull(f1_wfull), .walmost_full(f1_waf), .rinc(rinc), .rdata(f1_rdata),
        .rempty(f1_rempty), .ralmost_empty(f1_rae), .level(f1_level),
        .overflow(f1_ovf), .underflow(f1_unf), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] wr_vals  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [2:0] lvl_up   [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic       af_up    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       full_up  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       ae_up    [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] lvl_down [4] = '{3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        rst_n = 1'b0; wdata = '0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_rempty", 32'(r0_rempty), 32'd1);
        chk("rst_level", 32'(r0_level), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: idle after reset
        chk("t1_rempty", 32'(r0_rempty), 32'd1);
        chk("t1_wfull", 32'(r0_wfull), 32'd0);
        chk("t1_level", 32'(r0_level), 32'd0);
        chk("t1_rae", 32'(r0_rae), 32'd1);
        chk("t1_waf", 32'(r0_waf), 32'd0);
        chk("t1_ovf", 32'(r0_ovf), 32'd0);
        chk("t1_unf", 32'(r0_unf), 32'd0);
        chk("t1_rdata", 32'(r0_rdata), 32'd0);

        // 2: fill, overflow, drain in registered mode
        for (int i = 0; i < 4; i++) begin
            winc = 1'b1; wdata = wr_vals[i];
            tick();
            chk("t2_level_up", 32'(r0_level), 32'(lvl_up[i]));
            chk("t2_waf", 32'(r0_waf), 32'(af_up[i]));
            chk("t2_wfull", 32'(r0_wfull), 32'(full_up[i]));
            chk("t2_rae", 32'(r0_rae), 32'(ae_up[i]));
        end
        wdata = 8'h55;
        tick();
        winc = 1'b0;
        chk("t2_ovf", 32'(r0_ovf), 32'd1);
        chk("t2_level_ovf", 32'(r0_level), 32'd4);
        chk("t2_fwft_head", 32'(f1_rdata), 32'h11);
        for (int i = 0; i < 4; i++) begin
            rinc = 1'b1;
            tick();
            chk("t2_rdata", 32'(r0_rdata), 32'(wr_vals[i]));
            chk("t2_level_down", 32'(r0_level), 32'(lvl_down[i]));
        end
        rinc = 1'b0;
        chk("t2_rempty", 32'(r0_rempty), 32'd1);

        // 3: underflow and err_clr priority
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("t3_unf", 32'(r0_unf), 32'd1);
        chk("t3_rdata_hold", 32'(r0_rdata), 32'h44);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_unf_clr", 32'(r0_unf), 32'd0);
        chk("t3_ovf_clr", 32'(r0_ovf), 32'd0);
        err_clr = 1'b1; rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("t3_unf_wins", 32'(r0_unf), 32'd1);
        tick();
        err_clr = 1'b0;
        chk("t3_unf_clr2", 32'(r0_unf), 32'd0);

        // 4: streaming at level 2 across pointer wrap, then full with both requests
        winc = 1'b1;
        wdata = 8'h00; tick();
        wdata = 8'h01; tick();
        chk("t4_level_pre", 32'(r0_level), 32'd2);
        rinc = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wdata = 8'(k + 2);
            tick();
            chk("t4_level_stream", 32'(r0_level), 32'd2);
            chk("t4_rdata_stream", 32'(r0_rdata), 32'(k));
        end
        rinc = 1'b0;
        wdata = 8'h0C; tick();
        wdata = 8'h0D; tick();
        chk("t4_full", 32'(r0_wfull), 32'd1);
        rinc = 1'b1; wdata = 8'h0E;
        tick();
        winc = 1'b0;
        chk("t4_level_fullboth", 32'(r0_level), 32'd3);
        chk("t4_ovf", 32'(r0_ovf), 32'd1);
        chk("t4_rdata_fullboth", 32'(r0_rdata), 32'h0A);
        chk("t4_fwft_head", 32'(f1_rdata), 32'h0B);
        tick(); chk("t4_drain0", 32'(r0_rdata), 32'h0B);
        tick(); chk("t4_drain1", 32'(r0_rdata), 32'h0C);
        tick(); chk("t4_drain2", 32'(r0_rdata), 32'h0D);
        rinc = 1'b0;
        chk("t4_empty", 32'(r0_rempty), 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // 5: FWFT fall-through
        winc = 1'b1; wdata = 8'hA5;
        tick();
        winc = 1'b0;
        chk("t5_rempty", 32'(f1_rempty), 32'd0);
        chk("t5_rdata", 32'(f1_rdata), 32'hA5);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("t5_rempty_pop", 32'(f1_rempty), 32'd1);
        chk("t5_unf", 32'(f1_unf), 32'd0);

        // 6: reset mid-burst, then no stale data
        winc = 1'b1;
        wdata = 8'h61; tick();
        wdata = 8'h62; tick();
        wdata = 8'h63; tick();
        chk("t6_level_pre", 32'(r0_level), 32'd3);
        wdata = 8'h64;
        rst_n = 1'b0;
        #1;
        chk("t6_level_rst", 32'(r0_level), 32'd0);
        chk("t6_rempty_rst", 32'(r0_rempty), 32'd1);
        chk("t6_wfull_rst", 32'(r0_wfull), 32'd0);
        chk("t6_rae_rst", 32'(r0_rae), 32'd1);
        chk("t6_waf_rst", 32'(r0_waf), 32'd0);
        chk("t6_rdata_rst", 32'(r0_rdata), 32'd0);
        chk("t6_fwft_level_rst", 32'(f1_level), 32'd0);
        winc = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        winc = 1'b1; wdata = 8'h77;
        tick();
        winc = 1'b0;
        chk("t6_level_new", 32'(r0_level), 32'd1);
        chk("t6_fwft_rdata", 32'(f1_rdata), 32'h77);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("t6_rdata_new", 32'(r0_rdata), 32'h77);
        chk("t6_rempty_new", 32'(r0_rempty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
